// File: rtl/mem_write_mapper.sv
// mem_write_mapper: CPU write path of the memory map.
// Accepts one write at a time, decodes the 16-bit virtual address and sequences
// the SRAM strobe, the graphic display port or the keyboard acknowledge.
// ROM and unmapped addresses are rejected as faults.
// Optional macro WRITE_FAULT_LATCH_EN: latch the last faulting address and a
// sticky fault flag (cleared by fault_clr, set wins over clear).
// wr_done, wr_fault and gfx_wr_en follow gfx_ready within the same cycle while
// waiting on the display port, so they are decoded from the state register.
module mem_write_mapper #(
    parameter int unsigned WE_CYCLES   = 2,
    parameter int unsigned GFX_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    output logic        wr_done,
    output logic        wr_fault,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_dout,
    output logic        ram_oe,
    output logic        ram_ce_n,
    output logic        ram_we_n,
    output logic [13:0] gfx_addr,
    output logic [15:0] gfx_data,
    output logic        gfx_wr_en,
    input  logic        gfx_ready,
    output logic        kbd_ack,
    output logic [15:0] fault_addr,
    output logic        fault_flag,
    input  logic        fault_clr
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned GADDR_W = 14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_GFX,
        S_KBD,
        S_FAULT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    state_t             dec_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               accept;
    logic [ADDR_W-1:0]  gfx_off;

    assign gfx_off = wr_addr - 16'hF000;

    // Address decode in priority order: RAM, ROM, graphic window, keyboard, rest faults
    always_comb begin
        dec_state = S_FAULT;
        if (!wr_addr[15]) begin
            dec_state = S_SETUP;
        end else if (wr_addr[15:8] == 8'hFF) begin
            dec_state = S_FAULT;
        end else if (wr_addr[15:8] >= 8'hF0 && wr_addr[15:8] < 8'hFA) begin
            dec_state = S_GFX;
        end else if (wr_addr == 16'hFE00) begin
            dec_state = S_KBD;
        end
    end

    // State and cycle counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        wr_ready  = 1'b0;
        wr_done   = 1'b0;
        wr_fault  = 1'b0;
        ram_oe    = 1'b0;
        ram_ce_n  = 1'b1;
        ram_we_n  = 1'b1;
        gfx_wr_en = 1'b0;
        kbd_ack   = 1'b0;
        case (state)
            S_IDLE: begin
                wr_ready = 1'b1;
                if (wr_req) begin
                    accept    = 1'b1;
                    state_nxt = dec_state;
                    cnt_nxt   = '0;
                end
            end
            S_SETUP: begin
                ram_ce_n  = 1'b0;
                ram_oe    = 1'b1;
                state_nxt = S_STROBE;
                cnt_nxt   = '0;
            end
            S_STROBE: begin
                ram_ce_n = 1'b0;
                ram_oe   = 1'b1;
                ram_we_n = 1'b0;
                if (cnt == CNT_W'(WE_CYCLES - 1)) begin
                    state_nxt = S_HOLD;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                ram_ce_n  = 1'b0;
                ram_oe    = 1'b1;
                wr_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_GFX: begin
                if (gfx_ready) begin
                    gfx_wr_en = 1'b1;
                    wr_done   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_W'(GFX_TIMEOUT - 1)) begin
                    wr_done   = 1'b1;
                    wr_fault  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_KBD: begin
                kbd_ack   = 1'b1;
                wr_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_FAULT: begin
                wr_done   = 1'b1;
                wr_fault  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture target address/data at accept; held stable for the whole access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
            ram_dout <= '0;
            gfx_addr <= '0;
            gfx_data <= '0;
        end else if (accept) begin
            if (dec_state == S_SETUP) begin
                ram_addr <= {1'b0, wr_addr[15:1]};
                ram_dout <= wr_data;
            end
            if (dec_state == S_GFX) begin
                gfx_addr <= gfx_off[GADDR_W-1:0];
                gfx_data <= wr_data;
            end
        end
    end

`ifdef WRITE_FAULT_LATCH_EN
    logic [ADDR_W-1:0] acc_addr;

    // Remember the accepted address for fault reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_addr <= '0;
        end else if (accept) begin
            acc_addr <= wr_addr;
        end
    end

    // Sticky fault flag and last faulting address; a new fault beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_addr <= '0;
            fault_flag <= 1'b0;
        end else if (wr_fault) begin
            fault_addr <= acc_addr;
            fault_flag <= 1'b1;
        end else if (fault_clr) begin
            fault_flag <= 1'b0;
        end
    end
`else
    logic unused_fault_clr;

    assign fault_addr       = '0;
    assign fault_flag       = 1'b0;
    assign unused_fault_clr = fault_clr;
`endif

endmodule

// File: tb/tb_mem_write_mapper.sv
// Self-checking bench for mem_write_mapper (WE_CYCLES=2, GFX_TIMEOUT=16).
module tb_mem_write_mapper;

    localparam int WE = 2;
    localparam int TO = 16;

    typedef enum int {K_RAM, K_GFX, K_KBD, K_FLT} kind_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        wr_done;
    logic        wr_fault;
    logic [15:0] ram_addr;
    logic [15:0] ram_dout;
    logic        ram_oe;
    logic        ram_ce_n;
    logic        ram_we_n;
    logic [13:0] gfx_addr;
    logic [15:0] gfx_data;
    logic        gfx_wr_en;
    logic        gfx_ready;
    logic        kbd_ack;
    logic [15:0] fault_addr;
    logic        fault_flag;
    logic        fault_clr;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_fault_addr = 16'h0;
    logic        m_flag       = 1'b0;

    mem_write_mapper #(.WE_CYCLES(WE), .GFX_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .wr_done    (wr_done),
        .wr_fault   (wr_fault),
        .ram_addr   (ram_addr),
        .ram_dout   (ram_dout),
        .ram_oe     (ram_oe),
        .ram_ce_n   (ram_ce_n),
        .ram_we_n   (ram_we_n),
        .gfx_addr   (gfx_addr),
        .gfx_data   (gfx_data),
        .gfx_wr_en  (gfx_wr_en),
        .gfx_ready  (gfx_ready),
        .kbd_ack    (kbd_ack),
        .fault_addr (fault_addr),
        .fault_flag (fault_flag),
        .fault_clr  (fault_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    // Memory map from address ranges
    function automatic kind_t classify(input logic [15:0] a);
        if (a < 16'h8000) return K_RAM;
        if (a >= 16'hFF00) return K_FLT;
        if (a >= 16'hF000 && a < 16'hFA00) return K_GFX;
        if (a == 16'hFE00) return K_KBD;
        return K_FLT;
    endfunction

    task automatic chk_fault_regs(input string tag);
`ifdef WRITE_FAULT_LATCH_EN
        chk(tag, "fault_addr", 32'(fault_addr), 32'(m_fault_addr));
        chk(tag, "fault_flag", 32'(fault_flag), 32'(m_flag));
`else
        chk(tag, "fault_addr", 32'(fault_addr), 32'h0);
        chk(tag, "fault_flag", 32'(fault_flag), 32'h0);
`endif
    endtask

    // One write; rdy_delay is the cycle after accept at which gfx_ready rises
    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int rdy_delay, input string tag);
        kind_t k_t;
        int    exp_done;
        bit    exp_fault;
        int    done_k  = -1;
        logic  flt     = 1'b0;
        int    we_cnt  = 0;
        int    we_first = -1;
        int    ce_cnt  = 0;
        int    oe_cnt  = 0;
        int    gen_cnt = 0;
        int    kbd_cnt = 0;
        logic [15:0] exp_gaddr;

        k_t = classify(a);
        case (k_t)
            K_RAM:   exp_done = WE + 2;
            K_GFX:   exp_done = (rdy_delay <= TO) ? rdy_delay : TO;
            default: exp_done = 1;
        endcase
        exp_fault = (k_t == K_FLT) || (k_t == K_GFX && rdy_delay > TO);

        @(posedge clk); #1;
        wr_req    = 1'b1;
        wr_addr   = a;
        wr_data   = d;
        gfx_ready = 1'b0;
        #1;
        chk(tag, "ready_at_accept", 32'(wr_ready), 32'h1);

        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            wr_req    = 1'b0;
            wr_addr   = 16'($urandom);
            wr_data   = 16'($urandom);
            gfx_ready = (k_t == K_GFX) ? (k >= rdy_delay) : 1'($urandom);
            #1;
            if (!ram_we_n) begin
                we_cnt++;
                if (we_first < 0) we_first = k;
            end
            if (!ram_ce_n) ce_cnt++;
            if (ram_oe) oe_cnt++;
            if (gfx_wr_en) gen_cnt++;
            if (kbd_ack) kbd_cnt++;
            if (wr_done) begin
                done_k = k;
                flt    = wr_fault;
                break;
            end
            if (wr_fault) flt = 1'b1;
        end

        chk(tag, "done_cycle", 32'(done_k), 32'(exp_done));
        chk(tag, "fault", 32'(flt), 32'(exp_fault));
        chk(tag, "we_low_cycles", 32'(we_cnt), (k_t == K_RAM) ? 32'(WE) : 32'h0);
        chk(tag, "ce_low_cycles", 32'(ce_cnt), (k_t == K_RAM) ? 32'(WE + 2) : 32'h0);
        chk(tag, "oe_cycles", 32'(oe_cnt), (k_t == K_RAM) ? 32'(WE + 2) : 32'h0);
        chk(tag, "gfx_wr_en_count", 32'(gen_cnt), (k_t == K_GFX && !exp_fault) ? 32'h1 : 32'h0);
        chk(tag, "kbd_ack_count", 32'(kbd_cnt), (k_t == K_KBD) ? 32'h1 : 32'h0);
        if (k_t == K_RAM) begin
            chk(tag, "we_first", 32'(we_first), 32'h2);
            chk(tag, "ram_addr", 32'(ram_addr), 32'(a / 2));
            chk(tag, "ram_dout", 32'(ram_dout), 32'(d));
        end
        if (k_t == K_GFX) begin
            exp_gaddr = a - 16'hF000;
            chk(tag, "gfx_addr", 32'(gfx_addr), 32'(exp_gaddr));
            chk(tag, "gfx_data", 32'(gfx_data), 32'(d));
        end
        if (exp_fault) begin
            m_fault_addr = a;
            m_flag       = 1'b1;
        end

        @(posedge clk); #1;
        gfx_ready = 1'b0;
        #1;
        chk(tag, "ready_after_done", 32'(wr_ready), 32'h1);
        chk(tag, "done_after", 32'(wr_done), 32'h0);
        chk_fault_regs(tag);
    endtask

    initial begin
        logic [15:0] a;
        int          r;

        rst_n     = 1'b0;
        wr_req    = 1'b0;
        wr_addr   = 16'h0;
        wr_data   = 16'h0;
        gfx_ready = 1'b0;
        fault_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", "wr_ready", 32'(wr_ready), 32'h1);
        chk("reset", "ram_ce_n", 32'(ram_ce_n), 32'h1);
        chk("reset", "ram_we_n", 32'(ram_we_n), 32'h1);
        chk("reset", "ram_oe", 32'(ram_oe), 32'h0);
        chk("reset", "wr_done", 32'(wr_done), 32'h0);
        chk("reset", "ram_addr", 32'(ram_addr), 32'h0);
        chk("reset", "gfx_addr", 32'(gfx_addr), 32'h0);
        chk("reset", "kbd_ack", 32'(kbd_ack), 32'h0);
        chk("reset", "fault_addr", 32'(fault_addr), 32'h0);
        chk("reset", "fault_flag", 32'(fault_flag), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed boundary cases
        do_write(16'h0246, 16'hBEEF, 1, "ram_0246");
        do_write(16'h7FFF, 16'h1234, 1, "ram_7fff");
        do_write(16'h0000, 16'h5678, 1, "ram_0000");
        do_write(16'hFF10, 16'hAAAA, 1, "rom_ff10");
        do_write(16'hFA00, 16'h5555, 1, "unm_fa00");
        do_write(16'hEFFF, 16'h0001, 1, "unm_efff");
        do_write(16'hFE01, 16'h0002, 1, "kbd_fe01");
        do_write(16'hFE00, 16'h0003, 1, "kbd_fe00");
        do_write(16'hF123, 16'h00FF, 4, "gfx_f123");
        do_write(16'hF9FF, 16'hC0DE, 1, "gfx_f9ff");
        do_write(16'hF123, 16'h00FF, 100, "gfx_timeout");
        do_write(16'hF000, 16'h0F0F, TO, "gfx_last_chance");

        // Clear the sticky flag; address is kept
        @(posedge clk); #1;
        fault_clr = 1'b1;
        @(posedge clk); #1;
        fault_clr = 1'b0;
        m_flag    = 1'b0;
        #1;
        chk_fault_regs("fault_clr");

        // wr_req held high through a keyboard write
        @(posedge clk); #1;
        wr_req  = 1'b1;
        wr_addr = 16'hFE00;
        #1;
        chk("held", "ready_t", 32'(wr_ready), 32'h1);
        @(posedge clk); #2;
        chk("held", "done_t1", 32'(wr_done), 32'h1);
        chk("held", "kbd_t1", 32'(kbd_ack), 32'h1);
        chk("held", "ready_t1", 32'(wr_ready), 32'h0);
        @(posedge clk); #2;
        chk("held", "ready_t2", 32'(wr_ready), 32'h1);
        chk("held", "kbd_t2", 32'(kbd_ack), 32'h0);
        @(posedge clk); #1;
        wr_req = 1'b0;
        #1;
        chk("held", "kbd_t3", 32'(kbd_ack), 32'h1);
        @(posedge clk); #2;
        chk("held", "ready_t4", 32'(wr_ready), 32'h1);

        // Reset in the middle of the write strobe
        @(posedge clk); #1;
        wr_req  = 1'b1;
        wr_addr = 16'h0246;
        wr_data = 16'hBEEF;
        @(posedge clk); #1;
        wr_req = 1'b0;
        @(posedge clk); #2;
        chk("rst_mid", "we_low_before", 32'(ram_we_n), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid", "we_n", 32'(ram_we_n), 32'h1);
        chk("rst_mid", "ce_n", 32'(ram_ce_n), 32'h1);
        chk("rst_mid", "oe", 32'(ram_oe), 32'h0);
        chk("rst_mid", "done", 32'(wr_done), 32'h0);
        m_fault_addr = 16'h0;
        m_flag       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        r = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            if (wr_done) r++;
        end
        chk("rst_mid", "done_count", 32'(r), 32'h0);
        chk("rst_mid", "ready", 32'(wr_ready), 32'h1);
        chk_fault_regs("rst_mid");

        // Randomized writes across the map
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 4));
            case (r)
                0:       a = 16'($urandom_range(0, 16'h7FFF));
                1:       a = 16'(16'hF000 + $urandom_range(0, 16'h09FF));
                2:       a = 16'hFE00;
                3:       a = 16'($urandom_range(16'h8000, 16'hFFFF));
                default: a = 16'(16'hFF00 + $urandom_range(0, 255));
            endcase
            do_write(a, 16'($urandom), int'($urandom_range(1, 20)), $sformatf("rand%0d_%h", n, a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
